// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO result registers.
// Latency: 32 busy cycles after accept, results and done on the next edge; start is ignored while busy.
module mul_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        is_div_q;
    logic        neg_q;
    logic        neg_r_q;
    logic        dz_q;
    logic [31:0] a_q;
    logic [31:0] mcand_q;
    logic [63:0] w_q;

    logic        a_neg_d;
    logic        b_neg_d;
    logic [31:0] a_mag_d;
    logic [31:0] b_mag_d;
    logic [32:0] sum_d;
    logic        ge_d;
    logic [31:0] sub_d;
    logic [63:0] w_d;
    logic [63:0] prod_d;
    logic [31:0] quo_d;
    logic [31:0] rem_d;
    logic [31:0] hi_fin_d;
    logic [31:0] lo_fin_d;

    // Operand conditioning: signed ops iterate on magnitudes, sign is fixed up at completion.
    always_comb begin
        a_neg_d = ~op[0] & a[31];
        b_neg_d = ~op[0] & b[31];
        a_mag_d = a_neg_d ? (~a + 32'd1) : a;
        b_mag_d = b_neg_d ? (~b + 32'd1) : b;
    end

    // One iteration step. Multiply keeps {partial, multiplier} in w_q; divide keeps {remainder, quotient}.
    always_comb begin
        sum_d = {1'b0, w_q[63:32]} + (w_q[0] ? {1'b0, mcand_q} : 33'd0);
        ge_d  = w_q[63:31] >= {1'b0, mcand_q};
        sub_d = w_q[62:31] - mcand_q;
        if (is_div_q) begin
            w_d = ge_d ? {sub_d, w_q[30:0], 1'b1} : {w_q[62:0], 1'b0};
        end else begin
            w_d = {sum_d, w_q[31:1]};
        end
    end

    always_comb begin
        prod_d = neg_q ? (~w_d + 64'd1) : w_d;
        quo_d  = neg_q ? (~w_d[31:0] + 32'd1) : w_d[31:0];
        rem_d  = neg_r_q ? (~w_d[63:32] + 32'd1) : w_d[63:32];
        if (!is_div_q) begin
            hi_fin_d = prod_d[63:32];
            lo_fin_d = prod_d[31:0];
        end else if (dz_q) begin
            hi_fin_d = a_q;
            lo_fin_d = 32'hFFFF_FFFF;
        end else begin
            hi_fin_d = rem_d;
            lo_fin_d = quo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 6'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            a_q      <= 32'd0;
            mcand_q  <= 32'd0;
            w_q      <= 64'd0;
        end else begin
            done_q <= 1'b0;
            // MTHI/MTLO land whenever the unit is not iterating, including the done cycle.
            if (hi_we && !busy_q) hi_q <= wdata;
            if (lo_we && !busy_q) lo_q <= wdata;
            if (flush) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_RUN: begin
                        w_q   <= w_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            hi_q    <= hi_fin_d;
                            lo_q    <= lo_fin_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_DONE;
                        end
                    end
                    default: begin
                        if (start) begin
                            state_q  <= S_RUN;
                            busy_q   <= 1'b1;
                            cnt_q    <= 6'd0;
                            is_div_q <= op[1];
                            neg_q    <= a_neg_d ^ b_neg_d;
                            neg_r_q  <= a_neg_d;
                            dz_q     <= (b == 32'd0);
                            a_q      <= a;
                            mcand_q  <= op[1] ? b_mag_d : a_mag_d;
                            w_q      <= {32'd0, op[1] ? a_mag_d : b_mag_d};
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation and waits for done; lat = edges after accept edge, bcyc = busy-high samples.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          output int lat, output int bcyc);
        op = o; a = x; b = y; start = 1'b1;
        step();
        start = 1'b0;
        bcyc = busy ? 1 : 0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin
                lat = i;
                break;
            end
            if (busy) bcyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd6;
        flush = 1'b0; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
        step(); step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mult();
        int lat, bcyc;
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, lat, bcyc);
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL mult_latency got %0d want 32", lat); end
        n_checks++; if (bcyc !== 32) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 32", bcyc); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done got %b want 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo got %h want fffffffa", lo); end
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle got %b want 0", done); end

        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
        n_checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin n_fail++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo); end
        step();
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, bcyc);
        n_checks++; if (hi !== 32'h4000_0000 || lo !== 32'd0) begin n_fail++; $display("FAIL mult_minmin got %h_%h want 40000000_00000000", hi, lo); end
        step();
    endtask

    task automatic test_div();
        int lat, bcyc;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bcyc);
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL div_latency got %0d want 32", lat); end
        n_checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg7_2 got hi=%h lo=%h want ffffffff fffffffd", hi, lo); end
        step();
        run_op(OP_DIVU, 32'd7, 32'd0, lat, bcyc);
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL divz_latency got %0d want 32", lat); end
        n_checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd7) begin n_fail++; $display("FAIL divu_by_zero got hi=%h lo=%h want 00000007 ffffffff", hi, lo); end
        step();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, lat, bcyc);
        n_checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL div_by_zero got hi=%h lo=%h want fffffff9 ffffffff", hi, lo); end
        step();
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcyc);
        n_checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin n_fail++; $display("FAIL div_overflow got hi=%h lo=%h want 00000000 80000000", hi, lo); end
        step();
        run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, lat, bcyc);
        n_checks++; if (lo !== 32'hFFFF_FFF2 || hi !== 32'd2) begin n_fail++; $display("FAIL div_100_neg7 got hi=%h lo=%h want 00000002 fffffff2", hi, lo); end
        step();
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h10, lat, bcyc);
        n_checks++; if (lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin n_fail++; $display("FAIL divu_big got hi=%h lo=%h want 0000000f 0fffffff", hi, lo); end
        step();
    endtask

    task automatic test_no_queue();
        int lat;
        int extra_done;
        op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
        step();
        a = 32'd3; b = 32'd3;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (done) begin lat = i; break; end
        end
        start = 1'b0;
        n_checks++; if (lat !== 32) begin n_fail++; $display("FAIL noqueue_latency got %0d want 32", lat); end
        n_checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'd1) begin n_fail++; $display("FAIL noqueue_result got %h_%h want fffffffe_00000001", hi, lo); end
        extra_done = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) extra_done++;
        end
        n_checks++; if (extra_done !== 0) begin n_fail++; $display("FAIL noqueue_second_op got %0d active cycles want 0", extra_done); end
    endtask

    task automatic test_back_to_back();
        int lat, bcyc, lat2;
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcyc);
        op = OP_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        lat2 = -1;
        for (int i = 1; i <= 40; i++) begin
            step();
            start = 1'b0;
            if (done) begin lat2 = i; break; end
        end
        n_checks++; if (lat2 !== 33) begin n_fail++; $display("FAIL b2b_spacing got %0d want 33", lat2); end
        n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL b2b_result got %h_%h want ffffffff_fffffffa", hi, lo); end
        // done cycle: MTHI must land since busy is low
        hi_we = 1'b1; wdata = 32'h1357_9BDF;
        step();
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h1357_9BDF) begin n_fail++; $display("FAIL done_cycle_mthi got %h want 13579bdf", hi); end
    endtask

    task automatic test_flush();
        int seen;
        hi_we = 1'b1; wdata = 32'h1111_2222; step(); hi_we = 1'b0;
        lo_we = 1'b1; wdata = 32'h3333_4444; step(); lo_we = 1'b0;
        op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        flush = 1'b1; start = 1'b1;
        step();
        flush = 1'b0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", busy); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (done || busy) seen++;
        end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flush_no_done got %0d active cycles want 0", seen); end
        n_checks++; if (hi !== 32'h1111_2222 || lo !== 32'h3333_4444) begin n_fail++; $display("FAIL flush_hilo got %h %h want 11112222 33334444", hi, lo); end
    endtask

    task automatic test_hilo_write();
        int lat;
        hi_we = 1'b1; wdata = 32'h0000_1234;
        step();
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_idle got %h want 00001234", hi); end
        // write with an accepted start takes effect, then the result overwrites it
        op = OP_MULTU; a = 32'd6; b = 32'd7; start = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_0000;
        step();
        start = 1'b0; lo_we = 1'b0;
        n_checks++; if (lo !== 32'hCAFE_0000) begin n_fail++; $display("FAIL mtlo_with_start got %h want cafe0000", lo); end
        step();
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        step();
        hi_we = 1'b0;
        n_checks++; if (hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi_busy got %h want 00001234", hi); end
        lat = -1;
        for (int i = 3; i <= 40; i++) begin
            step();
            if (done) begin lat = i; break; end
        end
        n_checks++; if (lat !== 32 || hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL mtlo_overwrite got lat=%0d hi=%h lo=%h want 32 0 2a", lat, hi, lo); end
        step();
    endtask

    task automatic test_reset_mid();
        op = OP_MULT; a = 32'hFFFF_FFFE; b = 32'd3; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst_n = 1'b0; start = 1'b1;
        step();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want all 0", busy, done, hi, lo);
        end
        step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_start_ignored got busy=%b want 0", busy); end
        start = 1'b0; rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = 32'd0; b = 32'd0;
        flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_no_queue();
        test_back_to_back();
        test_flush();
        test_hilo_write();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
